// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
// Also used by the optional REGFILE_WB_ARB_PERF_EN build of regfile_wb_arbiter.
package regfile_pkg;

    localparam logic [4:0] REG_XZR = 5'd31;
    localparam int         NREGS   = 32;
    localparam int         DATA_W  = 64;

    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [4:0] r);
        return {{(NREGS-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry in-order queue of writeback requests with a per-entry valid view
// so the parent can build the pending-write scoreboard.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_req_t               din,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output wb_req_t               head,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH-1:0][4:0] ent_addr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t       mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (PW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (PW+1)'(1);
            end
        end
    end

    // Slot gi holds live data when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [PW-1:0] off;
        assign off           = PW'(gi) - rd_ptr_reg;
        assign ent_valid[gi] = ({1'b0, off} < count_reg);
        assign ent_addr[gi]  = mem_reg[gi].addr;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the regfile write port between ALU (A) and load (B) writeback,
// with a pending-write scoreboard. Define REGFILE_WB_ARB_PERF_EN for conflict/stall counters.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int N     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [4:0]   a_addr,
    input  logic [N-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [4:0]   b_addr,
    input  logic [N-1:0] b_data,
    output logic         we3,
    output logic [4:0]   wa3,
    output logic [N-1:0] wd3,
    output logic [31:0]  busy,
    output logic         idle
`ifdef REGFILE_WB_ARB_PERF_EN
    ,
    output logic [31:0]  conflict_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    logic                  a_full, a_empty, b_full, b_empty;
    logic                  a_push, b_push, a_pop, b_pop;
    logic                  a_vld, b_vld, grant_b;
    wb_req_t               a_head, b_head, win;
    logic [DEPTH-1:0]      a_ent_valid, b_ent_valid;
    logic [DEPTH-1:0][4:0] a_ent_addr, b_ent_addr;
    prio_t                 prio_reg;

    // XZR writes are acknowledged but never enqueued.
    assign a_ready = reset && !a_full;
    assign b_ready = reset && !b_full;
    assign a_push  = a_valid && a_ready && (a_addr != REG_XZR);
    assign b_push  = b_valid && b_ready && (b_addr != REG_XZR);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (a_push),
        .din       ('{addr: a_addr, data: DATA_W'(a_data)}),
        .pop       (a_pop),
        .full      (a_full),
        .empty     (a_empty),
        .head      (a_head),
        .ent_valid (a_ent_valid),
        .ent_addr  (a_ent_addr)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (b_push),
        .din       ('{addr: b_addr, data: DATA_W'(b_data)}),
        .pop       (b_pop),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_head),
        .ent_valid (b_ent_valid),
        .ent_addr  (b_ent_addr)
    );

    assign a_vld   = reset && !a_empty;
    assign b_vld   = reset && !b_empty;
    assign grant_b = b_vld && (!a_vld || (prio_reg == PRIO_B));
    assign a_pop   = a_vld && !grant_b;
    assign b_pop   = grant_b;

    assign win = grant_b ? b_head : a_head;
    assign we3 = a_vld || b_vld;
    assign wa3 = we3 ? win.addr : '0;
    assign wd3 = we3 ? N'(win.data) : '0;

    // Priority only rotates when both requesters actually contend.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_reg <= PRIO_A;
        end else if (a_vld && b_vld) begin
            prio_reg <= (prio_reg == PRIO_A) ? PRIO_B : PRIO_A;
        end
    end

    logic [2*DEPTH-1:0][NREGS-1:0] ent_mask;
    logic [NREGS-1:0]              busy_or;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
        assign ent_mask[gi]       = a_ent_valid[gi] ? reg_onehot(a_ent_addr[gi]) : '0;
        assign ent_mask[DEPTH+gi] = b_ent_valid[gi] ? reg_onehot(b_ent_addr[gi]) : '0;
    end

    always_comb begin
        busy_or = '0;
        for (int i = 0; i < 2*DEPTH; i++) begin
            busy_or = busy_or | ent_mask[i];
        end
    end

    assign busy = reset ? (busy_or & ~reg_onehot(REG_XZR)) : '0;
    assign idle = !reset || (a_empty && b_empty);

`ifdef REGFILE_WB_ARB_PERF_EN
    logic [31:0] conflict_cnt_reg;
    logic [31:0] stall_cnt_reg;
    logic        stall_now;

    assign stall_now = (a_valid && !a_ready) || (b_valid && !b_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt_reg <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            if (a_vld && b_vld && (conflict_cnt_reg != '1)) begin
                conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
            end
            if (stall_now && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
    assign stall_cnt    = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: queue-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int N     = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_valid, b_valid;
    logic         a_ready, b_ready;
    logic [4:0]   a_addr, b_addr;
    logic [N-1:0] a_data, b_data;
    logic         we3;
    logic [4:0]   wa3;
    logic [N-1:0] wd3;
    logic [31:0]  busy;
    logic         idle;
`ifdef REGFILE_WB_ARB_PERF_EN
    logic [31:0]  conflict_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .busy    (busy),
        .idle    (idle)
`ifdef REGFILE_WB_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two plain queues of pending writes and a priority flag.
    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        qa[$];
    ent_t        qb[$];
    bit          prio_b;
    logic [31:0] m_conf, m_stall;
    bit          hav, hbv, rda, rdb;

    always @(posedge clk) begin
        if (!reset) begin
            qa.delete();
            qb.delete();
            prio_b  = 1'b0;
            m_conf  = '0;
            m_stall = '0;
        end else begin
            hav = (qa.size() > 0);
            hbv = (qb.size() > 0);
            rda = (qa.size() < DEPTH);
            rdb = (qb.size() < DEPTH);
            if (hav && hbv && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
            if (((a_valid && !rda) || (b_valid && !rdb)) && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;
            if (hav && hbv) begin
                if (prio_b) void'(qb.pop_front());
                else        void'(qa.pop_front());
                prio_b = !prio_b;
            end else if (hav) begin
                void'(qa.pop_front());
            end else if (hbv) begin
                void'(qb.pop_front());
            end
            if (a_valid && rda && a_addr != 5'd31) qa.push_back('{a_addr, a_data});
            if (b_valid && rdb && b_addr != 5'd31) qb.push_back('{b_addr, b_data});
        end
    end

    logic        e_we, e_idle, e_ar, e_br;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [31:0] e_busy;
    logic [4:0]  wlog[$];

    always @(negedge clk) begin
        e_we   = reset && (qa.size() > 0 || qb.size() > 0);
        e_wa   = '0;
        e_wd   = '0;
        if (e_we) begin
            if (qa.size() > 0 && qb.size() > 0) begin
                e_wa = prio_b ? qb[0].a : qa[0].a;
                e_wd = prio_b ? qb[0].d : qa[0].d;
            end else if (qa.size() > 0) begin
                e_wa = qa[0].a;
                e_wd = qa[0].d;
            end else begin
                e_wa = qb[0].a;
                e_wd = qb[0].d;
            end
        end
        e_busy = '0;
        foreach (qa[k]) e_busy[qa[k].a] = 1'b1;
        foreach (qb[k]) e_busy[qb[k].a] = 1'b1;
        e_busy[31] = 1'b0;
        if (!reset) e_busy = '0;
        e_idle = !reset || (qa.size() == 0 && qb.size() == 0);
        e_ar   = reset && (qa.size() < DEPTH);
        e_br   = reset && (qb.size() < DEPTH);
        chk("m_we3", 64'(we3), 64'(e_we));
        chk("m_wa3", 64'(wa3), 64'(e_wa));
        chk("m_wd3", wd3, e_wd);
        chk("m_busy", 64'(busy), 64'(e_busy));
        chk("m_idle", 64'(idle), 64'(e_idle));
        chk("m_a_ready", 64'(a_ready), 64'(e_ar));
        chk("m_b_ready", 64'(b_ready), 64'(e_br));
`ifdef REGFILE_WB_ARB_PERF_EN
        chk("m_conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
        chk("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        if (we3) wlog.push_back(wa3);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!idle && n < 20) begin
            step();
            #1;
            n++;
        end
        chk(name, 64'(idle), 64'd1);
    endtask

    bit seen_a0, seen_b0;

    initial begin
        reset   = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 64'h1;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 64'h0;

        // Reset held three cycles with a_valid asserted.
        repeat (3) begin
            step();
            #1;
            chk("rst_a_ready", 64'(a_ready), 64'd0);
            chk("rst_we3", 64'(we3), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_idle", 64'(idle), 64'd1);
        end
        reset   = 1'b1;
        a_valid = 1'b0;
        #1;
        chk("post_rst_a_ready", 64'(a_ready), 64'd1);

        // Single A write: presented next cycle, gone the cycle after.
        step();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h1234;
        step();
        a_valid = 1'b0;
        #1;
        chk("single_we3", 64'(we3), 64'd1);
        chk("single_wa3", 64'(wa3), 64'd5);
        chk("single_wd3", wd3, 64'h1234);
        chk("single_busy", 64'(busy), 64'h20);
        step();
        #1;
        chk("single_busy_clr", 64'(busy), 64'd0);
        chk("single_idle", 64'(idle), 64'd1);

        // Both requesters push every cycle: alternating writes, both queues fill.
        wlog.delete();
        seen_a0 = 1'b0;
        seen_b0 = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hA;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hB;
        repeat (6) begin
            step();
            #1;
            if (!a_ready) seen_a0 = 1'b1;
            if (!b_ready) seen_b0 = 1'b1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        drain("both_drain");
        chk("both_a_full_seen", 64'(seen_a0), 64'd1);
        chk("both_b_full_seen", 64'(seen_b0), 64'd1);
        chk("both_nwrites", 64'(wlog.size() >= 4), 64'd1);
        if (wlog.size() >= 4) begin
            chk("both_w0", 64'(wlog[0]), 64'd1);
            chk("both_w1", 64'(wlog[1]), 64'd2);
            chk("both_w2", 64'(wlog[2]), 64'd1);
            chk("both_w3", 64'(wlog[3]), 64'd2);
        end

        // XZR write is acknowledged and dropped.
        step();
        b_valid = 1'b1; b_addr = 5'd31; b_data = 64'hFFFF;
        #1;
        chk("xzr_b_ready", 64'(b_ready), 64'd1);
        step();
        b_valid = 1'b0;
        #1;
        chk("xzr_we3", 64'(we3), 64'd0);
        chk("xzr_busy", 64'(busy), 64'd0);
        chk("xzr_idle", 64'(idle), 64'd1);

        // A-only fills: drain keeps pace with fill, order preserved across pointer wrap.
        wlog.delete();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h33;
        step();
        a_addr = 5'd4; a_data = 64'h44;
        #1;
        chk("fill_a_ready0", 64'(a_ready), 64'd1);
        step();
        a_addr = 5'd6; a_data = 64'h66;
        #1;
        chk("fill_a_ready1", 64'(a_ready), 64'd1);
        step();
        a_addr = 5'd7; a_data = 64'h77;
        step();
        a_valid = 1'b0;
        drain("fill_drain");
        chk("fill_nwrites", 64'(wlog.size()), 64'd4);
        if (wlog.size() == 4) begin
            chk("fill_w0", 64'(wlog[0]), 64'd3);
            chk("fill_w1", 64'(wlog[1]), 64'd4);
            chk("fill_w2", 64'(wlog[2]), 64'd6);
            chk("fill_w3", 64'(wlog[3]), 64'd7);
        end

        // Reset while both queues hold entries.
        a_valid = 1'b1; a_addr = 5'd10; a_data = 64'h10;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 64'h11;
        step();
        step();
        #1;
        chk("midrst_pre_idle", 64'(idle), 64'd0);
        reset   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        #1;
        chk("midrst_we3", 64'(we3), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_idle", 64'(idle), 64'd1);
`ifdef REGFILE_WB_ARB_PERF_EN
        chk("midrst_conflict", 64'(conflict_cnt), 64'd0);
`endif
        reset = 1'b1;
        step();
        #1;
        chk("midrst_after_we3", 64'(we3), 64'd0);
        chk("midrst_after_idle", 64'(idle), 64'd1);

        // Mixed traffic table: repeated registers, XZR entries, contention.
        for (int i = 0; i < 48; i++) begin
            a_valid = (i % 3) != 0;
            a_addr  = (i % 5 == 0) ? 5'd31 : 5'(i % 4);
            a_data  = 64'(i) * 64'h101;
            b_valid = (i % 2) == 0;
            b_addr  = 5'((i * 7 + 3) % 32);
            b_data  = ~64'(i);
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        drain("mix_drain");

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
